// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the PRBS31 checker.
//   HIST_W      : width of the received-bit history (31)
//   TAP_A/TAP_B : polynomial taps x^31 + x^28 + 1
//   FILL_BYTES  : bytes accepted unchecked after reset before searching
//   state_t     : checker FSM states (FILL=0, SEARCH=1, LOCKED=2)
//   popcount8   : number of set bits in a byte
package prbs_pkg;

  localparam int unsigned HIST_W     = 31;
  localparam int unsigned TAP_A      = 31;
  localparam int unsigned TAP_B      = 28;
  localparam int unsigned FILL_BYTES = 4;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/prbs31_predict8.sv
// prbs31_predict8: combinational 8-bit PRBS31 prediction.
//   hist      in  : history, hist[0] newest received bit
//   din       in  : received byte, din[7] oldest bit, din[0] newest
//   pred      out : predicted byte, same bit ordering as din
//   hist_next out : history after shifting in din[7]..din[0]
// Each bit is predicted from the history including the earlier received
// bits of the same byte, so the checker re-synchronises on the received data.
module prbs31_predict8
  import prbs_pkg::*;
(
  input  logic [HIST_W-1:0] hist,
  input  logic [7:0]        din,
  output logic [7:0]        pred,
  output logic [HIST_W-1:0] hist_next
);

  logic [HIST_W-1:0] work;

  always_comb begin
    work = hist;
    pred = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      pred[7-i] = work[TAP_A-1] ^ work[TAP_B-1];
      work      = {work[HIST_W-2:0], din[7-i]};
    end
    hist_next = work;
  end

endmodule

// File: rtl/prbs31_checker.sv
// prbs31_checker: byte-wide self-synchronising PRBS31 (x^31+x^28+1) checker.
//   clk       in  : clock, rising edge
//   rst_n     in  : asynchronous active-low reset
//   din_valid in  : din holds a stream byte this cycle
//   din       in  : 8 stream bits, din[7] oldest, din[0] newest
//   clr_cnt   in  : synchronous clear of err_cnt (applied before any increment)
//   locked    out : checker locked (state == LOCKED)
//   state     out : 0 FILL, 1 SEARCH, 2 LOCKED
//   err_pulse out : last accepted byte mismatched while locked
//   err_cnt   out : saturating error count
// Build option: define PRBS_CHK_BITCNT_EN to count mismatched bits per
// errored byte instead of one per errored byte.
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_GOOD  = 16,
  parameter int unsigned UNLOCK_BAD = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [7:0]       din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned GOOD_W = $clog2(LOCK_GOOD + 1);
  localparam int unsigned BAD_W  = $clog2(UNLOCK_BAD + 1);
  localparam int unsigned SUM_W  = ((CNT_W > 4) ? CNT_W : 4) + 1;

  state_t            state_q, state_d;
  logic [HIST_W-1:0] hist_q, hist_d, hist_next;
  logic [1:0]        fill_q, fill_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic              pulse_q, pulse_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
  logic [SUM_W-1:0]  cnt_sum;
  logic [3:0]        inc;
  logic [7:0]        pred, mismatch;
  logic              byte_err, hist_zero;

  prbs31_predict8 u_predict (
    .hist      (hist_q),
    .din       (din),
    .pred      (pred),
    .hist_next (hist_next)
  );

  assign mismatch  = din ^ pred;
  assign byte_err  = |mismatch;
  // An all-zero history predicts zeros forever; never treat that as clean.
  assign hist_zero = (hist_q == '0);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    good_d  = good_q;
    bad_d   = bad_q;
    pulse_d = 1'b0;
    inc     = '0;

    if (din_valid) begin
      hist_d = hist_next;
      case (state_q)
        ST_FILL: begin
          if (fill_q == 2'(FILL_BYTES - 1)) begin
            state_d = ST_SEARCH;
            fill_d  = '0;
            good_d  = '0;
          end else begin
            fill_d = fill_q + 2'd1;
          end
        end
        ST_SEARCH: begin
          if (byte_err || hist_zero) begin
            good_d = '0;
          end else if (good_q == GOOD_W'(LOCK_GOOD - 1)) begin
            state_d = ST_LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
        end
        ST_LOCKED: begin
          pulse_d = byte_err;
          if (byte_err) begin
`ifdef PRBS_CHK_BITCNT_EN
            inc = popcount8(mismatch);
`else
            inc = 4'd1;
`endif
            if (bad_q == BAD_W'(UNLOCK_BAD - 1)) begin
              state_d = ST_SEARCH;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + BAD_W'(1);
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end

    // Clear first, then add with saturation.
    cnt_base = clr_cnt ? '0 : cnt_q;
    cnt_sum  = SUM_W'(cnt_base) + SUM_W'(inc);
    if (cnt_sum > SUM_W'({CNT_W{1'b1}})) begin
      cnt_d = '1;
    end else begin
      cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign state     = state_q;
  assign err_pulse = pulse_q;
  assign err_cnt   = cnt_q;

endmodule
